// File: rtl/gcd_bin_rtl.sv
// Iterative binary (Stein) GCD engine with start/rdy handshake, busy flag and done strobe.
// Optional GCD_CYCLES_EN adds a 'cycles' output reporting accept-to-done edge count.
module gcd_bin_rtl #(
    parameter int unsigned NBits  = 16,
    parameter bit          Signed = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBits-1:0] xi,
    input  logic [NBits-1:0] yi,
    output logic [NBits-1:0] xo,
    output logic             rdy,
    output logic             busy,
`ifdef GCD_CYCLES_EN
    output logic             done,
    output logic [$clog2(4*NBits+5)-1:0] cycles
`else
    output logic             done
`endif
);

    localparam int unsigned KW = $clog2(NBits) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StCommon,
        StOddx,
        StLoop,
        StFinal
    } state_t;

    state_t           state;
    logic [NBits-1:0] x;
    logic [NBits-1:0] y;
    logic [KW-1:0]    k;
    logic [NBits-1:0] xm;
    logic [NBits-1:0] ym;

`ifdef GCD_CYCLES_EN
    localparam int unsigned CW = $clog2(4*NBits+5);
    logic [CW-1:0] cnt;
`endif

    // Negation in NBits wraps the most negative value onto 2^(NBits-1), its true magnitude.
    always_comb begin
        xm = xi;
        ym = yi;
        if (Signed && xi[NBits-1]) xm = NBits'(0) - xi;
        if (Signed && yi[NBits-1]) ym = NBits'(0) - yi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            x     <= '0;
            y     <= '0;
            k     <= '0;
            xo    <= '0;
            rdy   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef GCD_CYCLES_EN
            cnt    <= '0;
            cycles <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef GCD_CYCLES_EN
            if (state != StIdle) cnt <= cnt + CW'(1);
`endif
            unique case (state)
                StIdle: begin
                    if (start) begin
                        x    <= xm;
                        y    <= ym;
                        k    <= '0;
                        rdy  <= 1'b0;
                        busy <= 1'b1;
`ifdef GCD_CYCLES_EN
                        cnt  <= CW'(1);
`endif
                        if (xm == '0) begin
                            x     <= ym;
                            state <= StFinal;
                        end else if (ym == '0) begin
                            state <= StFinal;
                        end else begin
                            state <= StCommon;
                        end
                    end
                end
                StCommon: begin
                    if (!x[0] && !y[0]) begin
                        x <= x >> 1;
                        y <= y >> 1;
                        k <= k + KW'(1);
                    end else begin
                        state <= StOddx;
                    end
                end
                StOddx: begin
                    if (!x[0]) x <= x >> 1;
                    else       state <= StLoop;
                end
                StLoop: begin
                    // x stays odd here; y is reduced until it reaches zero.
                    if (y == '0) begin
                        state <= StFinal;
                    end else if (!y[0]) begin
                        y <= y >> 1;
                    end else if (x > y) begin
                        x <= y;
                        y <= x - y;
                    end else begin
                        y <= y - x;
                    end
                end
                StFinal: begin
                    xo    <= x << k;
                    done  <= 1'b1;
                    rdy   <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
`ifdef GCD_CYCLES_EN
                    cycles <= cnt + CW'(1);
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_bin_rtl.sv
// Self-checking bench for gcd_bin_rtl: one unsigned and one signed instance against a
// modulo-based Euclid reference model.
module tb_gcd_bin_rtl;

    localparam int MaxLat = 4 * 16 + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        us, ss;
    logic [15:0] ux, uy, sx, sy, uxo, sxo;
    logic        urdy, ubusy, udone, srdy, sbusy, sdone;
`ifdef GCD_CYCLES_EN
    logic [6:0]  ucyc, scyc;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    gcd_bin_rtl #(.NBits(16), .Signed(1'b0)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (us),
        .xi    (ux),
        .yi    (uy),
        .xo    (uxo),
        .rdy   (urdy),
        .busy  (ubusy),
`ifdef GCD_CYCLES_EN
        .done  (udone),
        .cycles(ucyc)
`else
        .done  (udone)
`endif
    );

    gcd_bin_rtl #(.NBits(16), .Signed(1'b1)) s_dut (
        .clk   (clk),
        .rst   (rst),
        .start (ss),
        .xi    (sx),
        .yi    (sy),
        .xo    (sxo),
        .rdy   (srdy),
        .busy  (sbusy),
`ifdef GCD_CYCLES_EN
        .done  (sdone),
        .cycles(scyc)
`else
        .done  (sdone)
`endif
    );

    function automatic int mag(input bit sgn, input logic [15:0] v);
        int s;
        if (sgn) begin
            s = $signed(v);
            return (s < 0) ? -s : s;
        end
        return int'(v);
    endfunction

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Issues one operation and waits (bounded) for done; lat counts edges accept..done inclusive.
    task automatic do_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output int lat, output bit to,
                         output logic dn_next, output logic rdy_at_done, output int cyc);
        int w;
        res = '0; lat = 0; to = 1'b0; dn_next = 1'b0; rdy_at_done = 1'b0; cyc = 0; w = 0;
        @(negedge clk);
        while (!(sel ? srdy : urdy)) begin
            if (w >= 200) begin to = 1'b1; return; end
            @(negedge clk);
            w++;
        end
        if (sel) begin ss = 1'b1; sx = a; sy = b; end
        else     begin us = 1'b1; ux = a; uy = b; end
        @(posedge clk);
        @(negedge clk);
        us = 1'b0; ss = 1'b0;
        ux = 16'($urandom); uy = 16'($urandom); sx = 16'($urandom); sy = 16'($urandom);
        lat = 1;
        while (!(sel ? sdone : udone)) begin
            if (lat >= 200) begin to = 1'b1; return; end
            @(negedge clk);
            lat++;
        end
        res = sel ? sxo : uxo;
        rdy_at_done = sel ? srdy : urdy;
`ifdef GCD_CYCLES_EN
        cyc = sel ? int'(scyc) : int'(ucyc);
`endif
        @(negedge clk);
        dn_next = sel ? sdone : udone;
    endtask

    task automatic test_reset();
        logic [15:0] r; int lat; bit to; logic dn, rd; int cyc;
        n_cmp++;
        if (urdy !== 1'b1 || ubusy !== 1'b0 || udone !== 1'b0 || uxo !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b busy=%b done=%b xo=%0d, required 1 0 0 0",
                     urdy, ubusy, udone, uxo);
        end
        @(negedge clk); rst = 1'b0;
        do_op(1'b0, 16'd100, 16'd100, r, lat, to, dn, rd, cyc);
        n_cmp++;
        if (to || r !== 16'd100) begin
            n_fail++; $display("FAIL equal_100: xo=%0d to=%0d, required 100", r, to);
        end
        @(negedge clk); us = 1'b1; ux = 16'd48; uy = 16'd18;
        @(negedge clk); us = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ubusy !== 1'b1) begin
            n_fail++; $display("FAIL midrun_busy: busy=%b, required 1", ubusy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (urdy !== 1'b1 || ubusy !== 1'b0 || udone !== 1'b0 || uxo !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: rdy=%b busy=%b done=%b xo=%0d, required 1 0 0 0",
                     urdy, ubusy, udone, uxo);
        end
        @(negedge clk); rst = 1'b0;
        do_op(1'b0, 16'd48, 16'd18, r, lat, to, dn, rd, cyc);
        n_cmp++;
        if (to || r !== 16'd6 || lat > MaxLat) begin
            n_fail++; $display("FAIL after_reset_48_18: xo=%0d lat=%0d, required 6 lat<=%0d",
                               r, lat, MaxLat);
        end
    endtask

    task automatic test_known();
        logic [15:0] ta [8] = '{16'd17, 16'd100, 16'd1024, 16'd0, 16'd0,
                                16'hFFF4, 16'h8000, 16'hFFF9};
        logic [15:0] tb [8] = '{16'd13, 16'd100, 16'd96, 16'd35, 16'd0,
                                16'd18, 16'd0, 16'hFFEB};
        bit          tsel [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        logic [15:0] texp [8] = '{16'd1, 16'd100, 16'd32, 16'd35, 16'd0,
                                  16'd6, 16'h8000, 16'd7};
        logic [15:0] r; int lat; bit to; logic dn, rd; int cyc;
        for (int i = 0; i < 8; i++) begin
            do_op(tsel[i], ta[i], tb[i], r, lat, to, dn, rd, cyc);
            n_cmp++;
            if (to || r !== texp[i]) begin
                n_fail++; $display("FAIL known_%0d: xo=%h to=%0d, required %h", i, r, to, texp[i]);
            end
            n_cmp++;
            if (lat > MaxLat || ((ta[i] == 0 || tb[i] == 0) && lat != 2)) begin
                n_fail++; $display("FAIL known_lat_%0d: lat=%0d, required <=%0d (2 if zero)",
                                   i, lat, MaxLat);
            end
            n_cmp++;
            if (dn !== 1'b0 || rd !== 1'b1) begin
                n_fail++; $display("FAIL known_strobe_%0d: done_next=%b rdy=%b, required 0 1",
                                   i, dn, rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0; int ndone = 0; int bad = 0;
        logic [15:0] r = '0;
        @(negedge clk);
        us = 1'b1; ux = 16'hFFFF; uy = 16'd1;
        @(negedge clk);
        lat = 1;
        while (lat < 200) begin
            if ((urdy === ubusy) || (urdy && ubusy)) bad++;
            if (udone) begin
                ndone++;
                r = uxo;
                us = 1'b0;
                break;
            end
            ux = 16'($urandom); uy = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        repeat (4) begin
            @(negedge clk);
            if (udone) ndone++;
            if (urdy !== 1'b1 || ubusy !== 1'b0) bad++;
        end
        n_cmp++;
        if (r !== 16'd1 || ndone != 1) begin
            n_fail++; $display("FAIL spam_result: xo=%0d dones=%0d, required 1 1", r, ndone);
        end
        n_cmp++;
        if (lat > MaxLat) begin
            n_fail++; $display("FAIL spam_latency: lat=%0d, required <=%0d", lat, MaxLat);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL spam_rdy_busy: violations=%0d, required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r; int lat; bit to; logic dn, rd; int cyc; int e; bit sel;
        int sh;
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            sh = $urandom_range(0, 6);
            a = 16'($urandom) << sh;
            b = 16'($urandom) << sh;
            if ($urandom_range(0, 9) == 0) a = '0;
            if ($urandom_range(0, 9) == 0) b = 16'h8000;
            e = ref_gcd(mag(sel, a), mag(sel, b));
            do_op(sel, a, b, r, lat, to, dn, rd, cyc);
            n_cmp++;
            if (to || int'(r) != e || lat > MaxLat || dn !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d sel=%0d a=%h b=%h: xo=%h lat=%0d dn=%b, required %h lat<=%0d",
                         i, sel, a, b, r, lat, dn, 16'(e), MaxLat);
            end
`ifdef GCD_CYCLES_EN
            n_cmp++;
            if (cyc != lat) begin
                n_fail++; $display("FAIL random_cycles_%0d: cycles=%0d, required %0d", i, cyc, lat);
            end
`endif
        end
    endtask

    task automatic test_cycles();
`ifdef GCD_CYCLES_EN
        logic [15:0] r; int lat; bit to; logic dn, rd; int cyc;
        do_op(1'b0, 16'd0, 16'd5, r, lat, to, dn, rd, cyc);
        n_cmp++;
        if (to || cyc != 2 || r !== 16'd5) begin
            n_fail++; $display("FAIL cycles_zero: cycles=%0d xo=%0d, required 2 5", cyc, r);
        end
        do_op(1'b0, 16'd48, 16'd18, r, lat, to, dn, rd, cyc);
        n_cmp++;
        if (to || cyc != lat || r !== 16'd6) begin
            n_fail++; $display("FAIL cycles_48_18: cycles=%0d xo=%0d, required %0d 6", cyc, r, lat);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        us = 1'b0; ss = 1'b0; ux = '0; uy = '0; sx = '0; sy = '0;
        #1;
        test_reset();
        test_known();
        test_back_to_back();
        test_random();
        test_cycles();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_bin_rtl.md
Name: gcd_bin_rtl

Overview:
Iterative binary (Stein) GCD engine, successor to the subtractive gcd_rtl.
- Generalised in width (NBits) and operand mode (unsigned, or signed with magnitude taken).
- Adds a one-cycle done strobe, a busy flag and a guaranteed latency bound.
- Same start/rdy handshake as gcd_rtl; drops into existing benches and property binds.

Parameters:
NBits, 16, operand and result width (>=4).
Signed, 0, 0 = operands unsigned; 1 = operands two's complement, GCD of magnitudes.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; accepted only on a clk edge where rdy=1.
xi  input  NBits  operand X, sampled with accepted start.
yi  input  NBits  operand Y, sampled with accepted start.
xo  output  NBits  result; holds last result until next done.
rdy  output  1  high when idle and able to accept start.
busy  output  1  inverse of rdy (registered).
done  output  1  one-cycle pulse on the cycle xo is updated.

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset, including mid-operation: state=IDLE, xo=0, rdy=1, busy=0, done=0. Internal x, y, k cleared; any operation in flight is discarded.
- Internal registers: x, y (NBits, unsigned magnitudes); k (shift count, clog2(NBits)+1 bits).
- Operand conversion (Signed=1): magnitude = negative ? -v : v, taken as unsigned NBits. The most negative value maps to 2^(NBits-1) without overflow. Signed=0: no conversion.
- IDLE: on start=1, load x and y with the magnitudes, set k=0, rdy=0, busy=1.
  - If either magnitude is 0, go to FINAL with x = the other magnitude (both zero gives x=0).
  - Otherwise go to COMMON.
  - start=0 in IDLE: remain in IDLE.
- COMMON: if x and y are both even, x>>=1, y>>=1, k++; else go to ODDX.
- ODDX: if x is even, x>>=1; else go to LOOP.
- LOOP, one action per cycle, in priority order:
  1. y==0: go to FINAL.
  2. y even: y>>=1.
  3. x>y: x<=y, y<=x-y.
  4. else: y<=y-x.
  - Subtraction is unsigned NBits; the operand ordering above guarantees no underflow.
- FINAL: xo<=x<<k, done=1 for this edge only, rdy=1, busy=0; go to IDLE.
- Latency: from the accepting edge to the done edge is at most 4*NBits+4 cycles. The zero-operand path takes exactly 2 cycles.
- start while busy, or on the FINAL cycle (rdy=0), is ignored; no queueing.
- Changing xi/yi after acceptance has no effect on the current result.
- xo changes only on a done edge or on reset.
- Invariants:
  - rdy == !busy at all times.
  - done implies rdy on the following cycle.

Optional Feature:
GCD_CYCLES_EN
- Defined: adds output port cycles, width clog2(4*NBits+5). It counts clk edges from the accepting edge to the done edge, inclusive, and is updated together with xo on done. Reset value 0.
- Undefined: the port and counter are absent; behaviour and timing are otherwise identical.

Test Plan:
- NBits=16, Signed=0: reset asserted mid-run of (48,18) -> next cycle rdy=1, xo=0, done=0. Then start (48,18) -> done within 68 cycles, xo=6.
- Primes (17,13) -> xo=1. Equal (100,100) -> xo=100. Powers (1024,96) -> xo=32.
- Zero operands: (0,35) -> xo=35 with done exactly 2 cycles after accept. (0,0) -> xo=0.
- Signed=1: (-12,18) -> xo=6. (-32768,0) -> xo=16'h8000. (-7,-21) -> xo=7.
- Start pulsed every cycle during (65535,1): only the first request is accepted. xo=1 with latency <=68 cycles; rdy never high while busy.
- With GCD_CYCLES_EN defined: (0,5) -> cycles=2. (48,18) -> cycles equals the measured accept-to-done count.
